imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder serving the fetch stage's instruction requests over a valid/ready request/response handshake.
- Holds a word-addressed instruction store with configurable read latency and allows one outstanding request.
- Supports branch flush (cancels an in-flight fetch) and response backpressure (fetch stall).
- A load port fills the store from the bench or a boot loader.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words; power of two, at least 4.
- LATENCY, 2, cycles from request acceptance to rsp_valid; at least 1, at most 15.
- NOP_INST, 32'h00000013, instruction returned on an error response (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address of the instruction.
- req_ready  out  1  responder can accept a request this cycle.
- flush  in  1  branch redirect; cancels any pending or presented response.
- rsp_valid  out  1  response present.
- rsp_inst  out  32  fetched instruction.
- rsp_addr  out  32  byte address belonging to rsp_inst.
- rsp_err  out  1  address misaligned or out of range.
- rsp_ready  in  1  fetch stage consumes the response (low = stall).
- ld_en  in  1  load-port write enable.
- ld_addr  in  log2(DEPTH_WORDS)  word index for the load write.
- ld_data  in  32  load-port write data.

Behaviour:
- Reset, asynchronous while reset_n=0:
  - State goes to IDLE and the counter clears.
  - rsp_valid, rsp_inst, rsp_addr and rsp_err all go to 0.
  - req_ready is 0 while reset is asserted.
  - Memory contents are not reset.
  - Reset asserted mid-request discards that request; no response is ever produced for it.
- States:
  - IDLE: no request outstanding.
  - WAIT: latency countdown running.
  - RESP: response held on the outputs.
- req_ready is combinational:
  - req_ready = !flush & (IDLE | (RESP & rsp_ready)).
  - A request is accepted when req_valid & req_ready on a rising edge.
- Accept: the responder captures req_addr, clears rsp_valid, and moves to the next state as follows.
  - If LATENCY=1, it goes directly to RESP.
  - Otherwise it goes to WAIT with the counter loaded to LATENCY-1.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 1 and decrements, the state goes to RESP.
  - Result: rsp_valid rises after the LATENCY-th rising edge counted from the accepting edge.
- On entry to RESP:
  - rsp_inst, rsp_addr and rsp_err are registered.
  - The memory is read in that same cycle; a same-cycle ld_en write to that word gives the old data (read-before-write).
  - rsp_err = (addr[1:0] != 0) | (addr[31:2] >= DEPTH_WORDS).
  - If rsp_err is set, rsp_inst = NOP_INST.
- RESP:
  - Outputs hold stable while rsp_ready=0.
  - When rsp_ready=1, the response is consumed.
  - If a new request is accepted in that same cycle, the next state is WAIT (or RESP if LATENCY=1). Otherwise the state returns to IDLE and rsp_valid drops.
  - Throughput: one instruction per LATENCY cycles when back-to-back.
- flush (highest priority apart from reset):
  - In any state, the next state is IDLE and rsp_valid is 0 on the next edge.
  - The pending response is dropped without handshake.
  - No request is accepted in the flush cycle.
  - A response presented with rsp_ready=1 in the flush cycle counts as consumed; the consumer must ignore it.
- Load port:
  - When ld_en=1, mem[ld_addr] <= ld_data on the edge.
  - Load writes are independent of the FSM and legal in every state.
- rsp_addr is the full 32-bit captured address, including for error responses.

Test Plan:
- Load mem[0..3] = 32'h00500093, 32'h00108113, 32'h002081B3, 32'h00000013, then request addr 0x4 with LATENCY=2 → rsp_valid rises exactly 2 edges after acceptance, with rsp_inst=32'h00108113, rsp_addr=0x4, rsp_err=0.
- Back-to-back requests for 0x0, 0x4, 0x8 with rsp_ready held 1 → responses arrive in order, spaced 2 cycles apart, and req_ready is high on each consume cycle.
- Hold rsp_ready=0 for 5 cycles during RESP → rsp_valid, rsp_inst and rsp_addr stay stable and req_ready=0; on release the response is consumed once.
- Assert flush 1 cycle after accepting 0x8 → no rsp_valid follows; a request for 0x0 in the next cycle returns 32'h00500093.
- Request 0x6 (misaligned) and 0x400 (out of range for DEPTH_WORDS=256) → rsp_err=1, rsp_inst=32'h00000013, rsp_addr echoes the request.
- Pull reset_n low while in WAIT → outputs go to 0 immediately; after release, no stale response appears and mem[0] still reads 32'h00500093.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed store answering one outstanding
// fetch at a time after a fixed latency, with flush, stall and a load port.
module imem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_INST    = 32'h00000013,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    input  logic [31:0]   req_addr,
    output logic          req_ready,
    input  logic          flush,
    output logic          rsp_valid,
    output logic [31:0]   rsp_inst,
    output logic [31:0]   rsp_addr,
    output logic          rsp_err,
    input  logic          rsp_ready,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_inst_q;
    logic [31:0] rsp_addr_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic [31:0] src_addr;
    logic        rsp_err_d;
    logic [31:0] rsp_inst_d;

    assign req_ready = reset_n & ~flush &
                       ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
    assign accept    = req_valid & req_ready;

    // With single-cycle latency RESP is entered on the accepting edge itself,
    // so the response is built from the live request address.
    assign src_addr   = (LATENCY == 1) ? req_addr : addr_q;
    assign rsp_err_d  = (src_addr[1:0] != 2'b00) |
                        ({2'b00, src_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign rsp_inst_d = rsp_err_d ? NOP_INST : mem[src_addr[AW+1:2]];

    // Load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= 32'd0;
            rsp_addr_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_inst_q  <= rsp_inst_d;
                        rsp_addr_q  <= src_addr;
                        rsp_err_q   <= rsp_err_d;
                    end
                    cnt_q <= cnt_q - 4'd1;
                end
                IDLE, RESP: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_inst_q  <= rsp_inst_d;
                            rsp_addr_q  <= src_addr;
                            rsp_err_q   <= rsp_err_d;
                        end else begin
                            state_q     <= WAIT;
                            cnt_q       <= 4'(LATENCY - 1);
                            rsp_valid_q <= 1'b0;
                        end
                    end else if (state_q == RESP && rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_inst  = rsp_inst_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: table of single fetches plus hand-written
// back-to-back, stall, flush, load-collision and mid-request reset sequences.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        rsp_ready = 1'b0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'd0;
    logic [31:0] ld_data = 32'd0;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    imem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .NOP_INST(NOP)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_inst  (rsp_inst),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Single fetch from IDLE: checks latency, payload, then consumes it.
    task automatic do_req(input logic [31:0] a, input logic [31:0] exp_inst, input logic exp_err);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
        #1 chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 2);
        chk("rsp_inst", rsp_inst, exp_inst);
        chk("rsp_addr", rsp_addr, a);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        $display("fetch addr=%h inst=%h err=%0d latency=%0d", a, rsp_inst, rsp_err, n);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("consumed", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_inst [3];
        logic [31:0] held_inst;
        logic [31:0] held_addr;

        vecs[0] = '{32'h00000004, 32'h00108113, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00500093, 1'b0};
        vecs[2] = '{32'h00000008, 32'h002081B3, 1'b0};
        vecs[3] = '{32'h0000000C, 32'h00000013, 1'b0};
        vecs[4] = '{32'h000003FC, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{32'h00000006, NOP,          1'b1};
        vecs[6] = '{32'h00000400, NOP,          1'b1};
        vecs[7] = '{32'h00000001, NOP,          1'b1};
        vecs[8] = '{32'hFFFFFFFC, NOP,          1'b1};
        b2b_addr = '{32'h0, 32'h4, 32'h8};
        b2b_inst = '{32'h00500093, 32'h00108113, 32'h002081B3};

        // Reset state, with a request presented to prove req_ready is gated.
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_inst", rsp_inst, 32'd0);
        chk("rst_rsp_addr", rsp_addr, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        reset_n = 1'b1;

        load(8'd0, 32'h00500093);
        load(8'd1, 32'h00108113);
        load(8'd2, 32'h002081B3);
        load(8'd3, 32'h00000013);
        load(8'd4, 32'h11111111);
        load(8'd255, 32'hDEADBEEF);

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].addr, vecs[i].inst, vecs[i].err);
        end

        // Back-to-back fetches with rsp_ready held high.
        @(negedge clk);
        req_valid = 1'b1; req_addr = b2b_addr[0]; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_gap", 32'(rsp_valid), 32'd0);
            if (i < 2) req_addr = b2b_addr[i+1];
            else req_valid = 1'b0;
            @(negedge clk);
            chk("b2b_valid", 32'(rsp_valid), 32'd1);
            chk("b2b_inst", rsp_inst, b2b_inst[i]);
            chk("b2b_addr", rsp_addr, b2b_addr[i]);
            chk("b2b_req_ready", 32'(req_ready), 32'd1);
            $display("b2b addr=%h inst=%h", rsp_addr, rsp_inst);
        end
        @(negedge clk);
        chk("b2b_idle", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Stall for 5 cycles in RESP.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'hC;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        held_inst = rsp_inst;
        held_addr = rsp_addr;
        chk("stall_inst0", held_inst, 32'h00000013);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_inst", rsp_inst, 32'h00000013);
            chk("stall_addr", rsp_addr, 32'hC);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1 chk("release_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("release_consumed", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("release_once", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        $display("stall addr=%h inst=%h", held_addr, held_inst);

        // Flush one cycle after accepting 0x8, then refetch 0x0.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0; flush = 1'b1;
        #1 chk("flush_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_no_rsp0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("flush_no_rsp1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("flush_refetch_valid", 32'(rsp_valid), 32'd1);
        chk("flush_refetch_inst", rsp_inst, 32'h00500093);
        chk("flush_refetch_addr", rsp_addr, 32'h0);
        $display("flush refetch addr=%h inst=%h", rsp_addr, rsp_inst);

        // Flush while a response is stalled in RESP drops it.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_resp_drop", 32'(rsp_valid), 32'd0);

        // Load write to the word being read on RESP entry returns old data.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 8'd4; ld_data = 32'h22222222;
        @(negedge clk);
        ld_en = 1'b0;
        chk("rbw_valid", 32'(rsp_valid), 32'd1);
        chk("rbw_old", rsp_inst, 32'h11111111);
        $display("read-before-write addr=%h inst=%h", rsp_addr, rsp_inst);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        do_req(32'h10, 32'h22222222, 1'b0);

        // Reset asserted in WAIT, while the previous payload is still held.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h4;
        @(negedge clk);
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("wrst_valid", 32'(rsp_valid), 32'd0);
        chk("wrst_inst", rsp_inst, 32'd0);
        chk("wrst_addr", rsp_addr, 32'd0);
        chk("wrst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrst_no_stale", 32'(rsp_valid), 32'd0);
        end
        do_req(32'h0, 32'h00500093, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
